// File: rtl/tap_write_assembler.sv
// Assembles UART bytes (address byte + WRITE_WIDTH/8 little-endian data bytes) into one TAP register write.
// Optional inter-byte timeout in DATA is built only when TAP_WRITE_TIMEOUT_EN is defined.

package uart_pkg;
  parameter int IRLENGTH = 5;
endpackage

// Handshakes: a transfer happens in a cycle where valid and ready are both 1 at the
// rising clock edge; a valid source holds its data stable until that transfer, and
// valid never depends combinationally on ready.
module tap_write_assembler
  import uart_pkg::*;
#(
  parameter int WRITE_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [7:0]             RX_DATA_I,
  input  logic                   RX_VALID_I,
  output logic                   RX_READY_O,
  output logic [IRLENGTH-1:0]    WRITE_ADDRESS_O,
  output logic [WRITE_WIDTH-1:0] WRITE_DATA_O,
  output logic                   WRITE_VALID_O,
  input  logic                   WRITE_READY_I,
  output logic                   BUSY_O,
  output logic                   TIMEOUT_O,
  output logic [1:0]             STATE_O
);

  localparam int NBYTES = WRITE_WIDTH / 8;
  localparam int CW     = $clog2(NBYTES) + 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic          rx_accept;

  assign rx_accept = RX_VALID_I && RX_READY_O;
  assign STATE_O   = state;

`ifdef TAP_WRITE_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES - 1);

  logic [IW-1:0] idle_cnt;
  logic          idle_expired;

  assign idle_expired = (idle_cnt == IDLE_LIMIT);

  // Held at zero outside DATA, so entering DATA always starts a fresh count.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      idle_cnt <= '0;
    end else if (state != DATA || rx_accept) begin
      idle_cnt <= '0;
    end else if (!idle_expired) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign TIMEOUT_O = 1'b0;
`endif

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state           <= IDLE;
      byte_cnt        <= '0;
      WRITE_ADDRESS_O <= '0;
      WRITE_DATA_O    <= '0;
      WRITE_VALID_O   <= 1'b0;
      BUSY_O          <= 1'b0;
      RX_READY_O      <= 1'b0;
`ifdef TAP_WRITE_TIMEOUT_EN
      TIMEOUT_O       <= 1'b0;
`endif
    end else begin
`ifdef TAP_WRITE_TIMEOUT_EN
      TIMEOUT_O <= 1'b0;
`endif
      case (state)
        IDLE: begin
          RX_READY_O <= 1'b1;
          if (rx_accept) begin
            WRITE_ADDRESS_O <= RX_DATA_I[IRLENGTH-1:0];
            WRITE_DATA_O    <= '0;
            byte_cnt        <= '0;
            BUSY_O          <= 1'b1;
            state           <= DATA;
          end
        end
        DATA: begin
          if (rx_accept) begin
            for (int i = 0; i < NBYTES; i++) begin
              if (byte_cnt == CW'(i)) WRITE_DATA_O[8*i +: 8] <= RX_DATA_I;
            end
            byte_cnt <= byte_cnt + CW'(1);
            // Ready drops with the last byte so nothing can be accepted while the write waits.
            if (byte_cnt == LAST_BYTE) begin
              RX_READY_O    <= 1'b0;
              WRITE_VALID_O <= 1'b1;
              state         <= WRITE;
            end
          end
`ifdef TAP_WRITE_TIMEOUT_EN
          else if (idle_expired) begin
            BUSY_O    <= 1'b0;
            TIMEOUT_O <= 1'b1;
            state     <= IDLE;
          end
`endif
        end
        WRITE: begin
          if (WRITE_READY_I) begin
            WRITE_VALID_O <= 1'b0;
            BUSY_O        <= 1'b0;
            RX_READY_O    <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          WRITE_VALID_O <= 1'b0;
          BUSY_O        <= 1'b0;
          RX_READY_O    <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tap_write_assembler.sv
// Directed-vector bench for tap_write_assembler: frame assembly, write back-pressure,
// address truncation, mid-frame reset and the inter-byte timeout (TAP_WRITE_TIMEOUT_EN).
module tb_tap_write_assembler;

  localparam int W   = 32;
  localparam int IRL = uart_pkg::IRLENGTH;
  localparam int T   = 16;
  localparam int FW  = IRL + W;

  logic           CLK_I;
  logic           RST_I;
  logic [7:0]     RX_DATA_I;
  logic           RX_VALID_I;
  logic           RX_READY_O;
  logic [IRL-1:0] WRITE_ADDRESS_O;
  logic [W-1:0]   WRITE_DATA_O;
  logic           WRITE_VALID_O;
  logic           WRITE_READY_I;
  logic           BUSY_O;
  logic           TIMEOUT_O;
  logic [1:0]     STATE_O;

  int n_checks = 0;
  int n_fail = 0;
  int n_writes = 0;
  int n_timeout_cycles = 0;
  logic [FW-1:0] exp_q[$];

  tap_write_assembler #(
    .WRITE_WIDTH   (W),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK_I          (CLK_I),
    .RST_I          (RST_I),
    .RX_DATA_I      (RX_DATA_I),
    .RX_VALID_I     (RX_VALID_I),
    .RX_READY_O     (RX_READY_O),
    .WRITE_ADDRESS_O(WRITE_ADDRESS_O),
    .WRITE_DATA_O   (WRITE_DATA_O),
    .WRITE_VALID_O  (WRITE_VALID_O),
    .WRITE_READY_I  (WRITE_READY_I),
    .BUSY_O         (BUSY_O),
    .TIMEOUT_O      (TIMEOUT_O),
    .STATE_O        (STATE_O)
  );

  // Clock and watchdog
  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every completed write handshake is matched against the expected queue.
  always @(negedge CLK_I) begin
    #1;
    if (!RST_I && WRITE_VALID_O && WRITE_READY_I) begin
      n_writes++;
      if (exp_q.size() == 0) check("unexpected_write", 64'(exp_q.size()), 64'd1);
      else check("write_frame", 64'({WRITE_ADDRESS_O, WRITE_DATA_O}), 64'(exp_q.pop_front()));
    end
    if (TIMEOUT_O) n_timeout_cycles++;
  end

  // Driver tasks; called and returning on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    RX_DATA_I  = b;
    RX_VALID_I = 1'b1;
    while (!RX_READY_O && waited < 100) begin
      @(negedge CLK_I);
      waited++;
    end
    if (!RX_READY_O) begin
      check("rx_ready_wait", 64'(RX_READY_O), 64'd1);
      RX_VALID_I = 1'b0;
      return;
    end
    @(posedge CLK_I);
    @(negedge CLK_I);
    RX_VALID_I = 1'b0;
  endtask

  // seq holds the five bytes in send order, first byte in the top bits.
  task automatic send_frame(input logic [39:0] seq, input logic [IRL-1:0] exp_addr,
                            input logic [W-1:0] exp_data);
    exp_q.push_back({exp_addr, exp_data});
    for (int k = 0; k < 5; k++) send_byte(seq[39-8*k -: 8]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 64'(RX_READY_O), 64'd0);
    check({tag, "_valid"},    64'(WRITE_VALID_O), 64'd0);
    check({tag, "_busy"},     64'(BUSY_O), 64'd0);
    check({tag, "_timeout"},  64'(TIMEOUT_O), 64'd0);
    check({tag, "_addr"},     64'(WRITE_ADDRESS_O), 64'd0);
    check({tag, "_data"},     64'(WRITE_DATA_O), 64'd0);
    check({tag, "_state"},    64'(STATE_O), 64'd0);
  endtask

  int valid_cycles;
  int writes_before;
  int timeouts_before;

  initial begin
    RST_I         = 1'b1;
    RX_VALID_I    = 1'b0;
    RX_DATA_I     = 8'h00;
    WRITE_READY_I = 1'b0;
    @(negedge CLK_I);
    @(negedge CLK_I);
    check_reset_outputs("reset");
    RST_I = 1'b0;
    @(negedge CLK_I);
    check("ready_after_release", 64'(RX_READY_O), 64'd1);
    check("idle_busy", 64'(BUSY_O), 64'd0);

    // Back-to-back frame with the write accepted immediately
    WRITE_READY_I = 1'b1;
    send_frame(40'h03_78_56_34_12, IRL'(3), 32'h12345678);
    check("t1_valid", 64'(WRITE_VALID_O), 64'd1);
    check("t1_rx_ready_in_write", 64'(RX_READY_O), 64'd0);
    check("t1_busy_in_write", 64'(BUSY_O), 64'd1);
    check("t1_state_write", 64'(STATE_O), 64'd2);
    @(negedge CLK_I);
    check("t1_valid_one_cycle", 64'(WRITE_VALID_O), 64'd0);
    check("t1_rx_ready_after", 64'(RX_READY_O), 64'd1);
    check("t1_busy_after", 64'(BUSY_O), 64'd0);

    // Back-pressure: ready low 5 cycles, next address byte already offered
    WRITE_READY_I = 1'b0;
    send_frame(40'h03_78_56_34_12, IRL'(3), 32'h12345678);
    RX_DATA_I  = 8'h02;
    RX_VALID_I = 1'b1;
    valid_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (WRITE_VALID_O) valid_cycles++;
      check("t2_hold_payload", 64'({WRITE_ADDRESS_O, WRITE_DATA_O}),
            64'({IRL'(3), 32'h12345678}));
      check("t2_hold_rx_ready", 64'(RX_READY_O), 64'd0);
      @(negedge CLK_I);
    end
    WRITE_READY_I = 1'b1;
    if (WRITE_VALID_O) valid_cycles++;
    check("t2_hold_last_payload", 64'({WRITE_ADDRESS_O, WRITE_DATA_O}),
          64'({IRL'(3), 32'h12345678}));
    @(negedge CLK_I);
    check("t2_valid_cycles", 64'(valid_cycles), 64'd6);
    check("t2_valid_dropped", 64'(WRITE_VALID_O), 64'd0);
    check("t2_rx_ready_after", 64'(RX_READY_O), 64'd1);
    send_frame(40'h02_01_02_03_04, IRL'(2), 32'h04030201);
    @(negedge CLK_I);

    // Address byte upper bits are dropped
    send_frame(40'hFF_0D_F0_FE_CA, {IRL{1'b1}}, 32'hCAFEF00D);
    check("t3_addr_all_ones", 64'(WRITE_ADDRESS_O), 64'({IRL{1'b1}}));
    @(negedge CLK_I);

    // Reset mid-frame after the second data byte
    send_byte(8'h07);
    check("t4_busy_in_data", 64'(BUSY_O), 64'd1);
    check("t4_state_data", 64'(STATE_O), 64'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    RST_I = 1'b1;
    #1;
    check_reset_outputs("t4_async_reset");
    @(negedge CLK_I);
    RST_I = 1'b0;
    @(negedge CLK_I);
    check("t4_ready_after_release", 64'(RX_READY_O), 64'd1);
    send_frame(40'h01_AA_BB_CC_DD, IRL'(1), 32'hDDCCBBAA);
    @(negedge CLK_I);

    // Inter-byte gap after the first data byte
    writes_before   = n_writes;
    timeouts_before = n_timeout_cycles;
    send_byte(8'h04);
    send_byte(8'h11);
    repeat (20) @(negedge CLK_I);
`ifdef TAP_WRITE_TIMEOUT_EN
    check("t5_timeout_pulse_cycles", 64'(n_timeout_cycles - timeouts_before), 64'd1);
    check("t5_busy_after_timeout", 64'(BUSY_O), 64'd0);
    check("t5_state_idle", 64'(STATE_O), 64'd0);
    check("t5_no_write", 64'(n_writes - writes_before), 64'd0);
    send_frame(40'h04_44_33_22_11, IRL'(4), 32'h11223344);
`else
    check("t5_no_timeout", 64'(n_timeout_cycles - timeouts_before), 64'd0);
    check("t5_still_busy", 64'(BUSY_O), 64'd1);
    check("t5_still_data", 64'(STATE_O), 64'd1);
    exp_q.push_back({IRL'(4), 32'h44332211});
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
`endif
    @(negedge CLK_I);
    @(negedge CLK_I);
    check("frames_written", 64'(n_writes), 64'd6);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tap_write_assembler.md
TAP_WRITE_ASSEMBLER -- requirements
Module: tap_write_assembler

Interface
REQ-001 Parameter WRITE_WIDTH, default 32, write payload width in bits; SHALL be a multiple of 8 in the range 8..64.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, inter-byte timeout limit in clock cycles; used only when TAP_WRITE_TIMEOUT_EN is defined.
REQ-003 Constant IRLENGTH comes from uart_pkg and SHALL be at most 8.
REQ-004 CLK_I  input  1  sole clock; all state updates on the rising edge.
REQ-005 RST_I  input  1  asynchronous, active-high reset.
REQ-006 RX_DATA_I  input  8  byte from the UART receiver.
REQ-007 RX_VALID_I  input  1  RX_DATA_I is valid.
REQ-008 RX_READY_O  output  1  block accepts RX_DATA_I this cycle.
REQ-009 WRITE_ADDRESS_O  output  IRLENGTH  TAP register address for the assembled write.
REQ-010 WRITE_DATA_O  output  WRITE_WIDTH  assembled write payload.
REQ-011 WRITE_VALID_O  output  1  WRITE_ADDRESS_O and WRITE_DATA_O are valid.
REQ-012 WRITE_READY_I  input  1  downstream write interconnect accepts the write.
REQ-013 BUSY_O  output  1  a frame is partially received or pending.
REQ-014 TIMEOUT_O  output  1  one-cycle pulse when a frame is dropped on timeout.

Function
REQ-015 A frame SHALL be one address byte followed by NBYTES = WRITE_WIDTH/8 data bytes.
REQ-016 An RX byte SHALL be accepted only in a cycle where RX_VALID_I and RX_READY_O are both 1.
REQ-017 The FSM SHALL have exactly three states: IDLE, DATA and WRITE.
REQ-018 IDLE: RX_READY_O = 1; an accepted byte latches bits [IRLENGTH-1:0] into the address register, ignores the remaining bits, clears the data register to 0, clears the byte counter to 0, and moves to DATA.
REQ-019 DATA: RX_READY_O = 1; accepted byte k (0-based) is stored at WRITE_DATA_O[8k+7:8k] (little-endian), and the counter increments.
REQ-020 Acceptance of byte NBYTES-1 SHALL move the FSM to WRITE.
REQ-021 The counter SHALL be clog2(NBYTES)+1 bits wide and SHALL never wrap within a frame.
REQ-022 WRITE: RX_READY_O = 0 and WRITE_VALID_O = 1.
REQ-023 WRITE_VALID_O SHALL rise in the cycle after the last data byte is accepted (1-cycle latency).
REQ-024 In WRITE, WRITE_VALID_O SHALL stay 1 and WRITE_ADDRESS_O / WRITE_DATA_O SHALL stay stable until WRITE_READY_I = 1.
REQ-025 A cycle with WRITE_VALID_O = 1 and WRITE_READY_I = 1 completes the write; the FSM returns to IDLE and RX_READY_O = 1 from the next cycle.
REQ-026 WRITE_READY_I SHALL be ignored outside WRITE.
REQ-027 WRITE_VALID_O SHALL not depend combinationally on WRITE_READY_I.
REQ-028 RX_DATA_I is never accepted while in WRITE, so no byte can be lost.
REQ-029 BUSY_O = 1 in DATA and WRITE, else 0.
REQ-030 WRITE_ADDRESS_O and WRITE_DATA_O SHALL be driven from registers at all times; their value outside WRITE is don't-care but SHALL be deterministic.

Reset
REQ-031 While RST_I = 1: FSM = IDLE, counter = 0, address and data registers = 0, WRITE_VALID_O = 0, BUSY_O = 0, TIMEOUT_O = 0, RX_READY_O = 0.
REQ-032 Assertion of RST_I at any point mid-frame or in WRITE SHALL discard the frame immediately (asynchronously).
REQ-033 RX_READY_O SHALL become 1 in the first cycle after RST_I is released.

Configuration
REQ-034 Macro TAP_WRITE_TIMEOUT_EN defined: an idle counter increments each DATA cycle with no accepted byte and clears on each accepted byte and on entry to DATA.
REQ-035 With the macro defined, when the idle counter reaches TIMEOUT_CYCLES-1 in DATA, the partial frame is discarded, the FSM moves to IDLE, and TIMEOUT_O pulses 1 for one cycle.
REQ-036 With the macro defined, no timeout applies in WRITE or IDLE.
REQ-037 Macro not defined: no idle counter is built, TIMEOUT_O is tied to 0, and DATA waits indefinitely.

Verification
REQ-038 Bytes 0x03, 0x78, 0x56, 0x34, 0x12 back-to-back with WRITE_READY_I = 1 -> one cycle of WRITE_VALID_O with address 0x03 and data 0x12345678, then RX_READY_O = 1 the next cycle.
REQ-039 Same frame with WRITE_READY_I held 0 for 5 cycles -> WRITE_VALID_O held 6 cycles with stable outputs, RX_READY_O = 0 throughout, and the next RX byte is accepted only after the handshake.
REQ-040 Address byte 0xFF -> WRITE_ADDRESS_O equals all ones in IRLENGTH bits; upper bits are ignored.
REQ-041 RST_I pulsed after the 2nd data byte -> all outputs return to reset values; a following full frame 0x01, 0xAA, 0xBB, 0xCC, 0xDD yields data 0xDDCCBBAA.
REQ-042 With TAP_WRITE_TIMEOUT_EN and TIMEOUT_CYCLES = 16, address byte then 1 data byte then 16 idle cycles -> one TIMEOUT_O pulse, no WRITE_VALID_O, and a new frame is assembled correctly.
